// File: rtl/rc5_key_mix.sv
// RC5 key-expansion mixing engine: optional S-table init, then 3*max(T,C) S/L mix iterations.
// Optional feature macro: RC5_S_INIT_EN (adds INIT_S state and P/Q generator; otherwise S RAM is preloaded).
module rc5_key_mix #(
  parameter int unsigned W = 32,
  parameter int unsigned C = 4,
  parameter int unsigned R = 12
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(2*(R+1))-1:0]             S_address,
  output logic [W-1:0]                           S_wdata,
  output logic                                   S_we,
  input  logic [W-1:0]                           S_rdata,
  output logic [((C > 1) ? $clog2(C) : 1)-1:0]   L_address,
  output logic [W-1:0]                           L_wdata,
  output logic                                   L_we,
  input  logic [W-1:0]                           L_rdata
);

  localparam int unsigned T   = 2 * (R + 1);
  localparam int unsigned AW  = $clog2(T);
  localparam int unsigned CW  = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned LGW = $clog2(W);
  localparam int unsigned N   = 3 * ((T > C) ? T : C);
  localparam int unsigned KW  = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
`ifdef RC5_S_INIT_EN
    INIT_S,
`endif
    MIX_S,
    MIX_L,
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    ab_sum;
  logic [W-1:0]    s_sum;
  logic [W-1:0]    l_sum;

`ifdef RC5_S_INIT_EN
  localparam logic [63:0] P64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                (W == 32) ? 64'h0000_0000_B7E1_5163 :
                                            64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] Q64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                (W == 32) ? 64'h0000_0000_9E37_79B9 :
                                            64'h9E37_79B9_7F4A_7C15;
  localparam logic [W-1:0] P_W = P64[W-1:0];
  localparam logic [W-1:0] Q_W = Q64[W-1:0];

  logic [W-1:0] s_q, s_d;
`endif

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] s);
    if (s == '0) return x;
    return (x << s) | (x >> (W - int'(s)));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef RC5_S_INIT_EN
      s_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef RC5_S_INIT_EN
      s_q     <= s_d;
`endif
    end
  end

  // a_q already holds the updated A during MIX_L, so one A+B sum serves both phases.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
`ifdef RC5_S_INIT_EN
    s_d       = s_q;
`endif
    ab_sum    = a_q + b_q;
    s_sum     = S_rdata + ab_sum;
    l_sum     = L_rdata + ab_sum;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    S_address = '0;
    S_wdata   = '0;
    S_we      = 1'b0;
    L_address = '0;
    L_wdata   = '0;
    L_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          i_d = '0;
          j_d = '0;
          k_d = '0;
          a_d = '0;
          b_d = '0;
`ifdef RC5_S_INIT_EN
          s_d     = P_W;
          state_d = INIT_S;
`else
          state_d = MIX_S;
`endif
        end
      end
`ifdef RC5_S_INIT_EN
      INIT_S: begin
        S_address = i_q;
        S_wdata   = s_q;
        S_we      = 1'b1;
        s_d       = s_q + Q_W;
        if (i_q == AW'(T - 1)) begin
          i_d     = '0;
          state_d = MIX_S;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
`endif
      MIX_S: begin
        S_address = i_q;
        S_wdata   = rotl(s_sum, LGW'(3));
        S_we      = 1'b1;
        a_d       = S_wdata;
        state_d   = MIX_L;
      end
      MIX_L: begin
        L_address = j_q;
        L_wdata   = rotl(l_sum, ab_sum[LGW-1:0]);
        L_we      = 1'b1;
        b_d       = L_wdata;
        i_d       = (i_q == AW'(T - 1)) ? '0 : i_q + 1'b1;
        j_d       = (j_q == CW'(C - 1)) ? '0 : j_q + 1'b1;
        if (k_q == KW'(N - 1)) begin
          state_d = FINISH;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = MIX_S;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc5_key_mix.sv
// Bench for rc5_key_mix: behavioural RAMs, software RC5 key-schedule reference, C=4 and C=1 instances.
module tb_rc5_key_mix;

  localparam int T    = 26;
  localparam int NMIX = 78;
`ifdef RC5_S_INIT_EN
  localparam int INIT_T = 26;
`else
  localparam int INIT_T = 0;
`endif
  localparam int LAT = INIT_T + 2 * NMIX + 1;

  logic clk = 1'b0;
  logic rst, start, load_req;

  logic        busy0, done0, s_we0, l_we0;
  logic [4:0]  s_addr0;
  logic [1:0]  l_addr0;
  logic [31:0] s_wdata0, s_rdata0, l_wdata0, l_rdata0;

  logic        busy1, done1, s_we1, l_we1;
  logic [4:0]  s_addr1;
  logic [0:0]  l_addr1;
  logic [31:0] s_wdata1, s_rdata1, l_wdata1, l_rdata1;

  always #5 clk = ~clk;

  rc5_key_mix dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .S_address(s_addr0), .S_wdata(s_wdata0), .S_we(s_we0), .S_rdata(s_rdata0),
    .L_address(l_addr0), .L_wdata(l_wdata0), .L_we(l_we0), .L_rdata(l_rdata0)
  );

  rc5_key_mix #(.C(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .S_address(s_addr1), .S_wdata(s_wdata1), .S_we(s_we1), .S_rdata(s_rdata1),
    .L_address(l_addr1), .L_wdata(l_wdata1), .L_we(l_we1), .L_rdata(l_rdata1)
  );

  logic [31:0] s0_ram [32];
  logic [31:0] l0_ram [4];
  logic [31:0] s1_ram [32];
  logic [31:0] l1_ram [2];
  logic [31:0] s_img  [32];
  logic [31:0] l_img  [4];

  assign s_rdata0 = s0_ram[s_addr0];
  assign l_rdata0 = l0_ram[l_addr0];
  assign s_rdata1 = s1_ram[s_addr1];
  assign l_rdata1 = l1_ram[l_addr1];

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 32; k++) begin
        s0_ram[k] <= s_img[k];
        s1_ram[k] <= s_img[k];
      end
      for (int k = 0; k < 4; k++) l0_ram[k] <= l_img[k];
      l1_ram[0] <= l_img[0];
      l1_ram[1] <= '0;
    end else begin
      if (s_we0) s0_ram[s_addr0] <= s_wdata0;
      if (l_we0) l0_ram[l_addr0] <= l_wdata0;
      if (s_we1) s1_ram[s_addr1] <= s_wdata1;
      if (l_we1) l1_ram[l_addr1] <= l_wdata1;
    end
  end

  logic [31:0] s0_q [$];
  logic [31:0] l0_q [$];
  int proto_err = 0;
  int j1_err    = 0;
  int done0_cnt = 0;

  always @(negedge clk) begin
    if (s_we0) s0_q.push_back(s_wdata0);
    if (l_we0) l0_q.push_back(l_wdata0);
    if ((s_we0 && l_we0) || (s_we1 && l_we1)) proto_err++;
    if ((!busy0 && (s_we0 || l_we0)) || (!busy1 && (s_we1 || l_we1))) proto_err++;
    if (l_we1 && l_addr1 != 1'b0) j1_err++;
    if (done0) done0_cnt++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int s);
    int r;
    r = s & 31;
    if (r == 0) return x;
    return (x << r) | (x >> (32 - r));
  endfunction

  logic [31:0] m_s [26];
  logic [31:0] m_l [4];

  // Straight software RC5 key schedule on the key image.
  task automatic model(input int c);
    logic [31:0] a, b;
    int i, j, n;
    m_s[0] = 32'hB7E15163;
    for (int k = 1; k < 26; k++) m_s[k] = m_s[k-1] + 32'h9E3779B9;
    for (int k = 0; k < 4; k++) m_l[k] = l_img[k];
    n = 3 * ((c > 26) ? c : 26);
    a = '0; b = '0; i = 0; j = 0;
    for (int k = 0; k < n; k++) begin
      a = rol(m_s[i] + a + b, 3);
      m_s[i] = a;
      b = rol(m_l[j] + a + b, int'((a + b) & 32'd31));
      m_l[j] = b;
      i = (i + 1) % 26;
      j = (j + 1) % c;
    end
  endtask

  int lat0, lat1, busy_gap, sq_base, lq_base, dn_base;

  task automatic load_rams();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic run_op(input bit hold, input int abort_l);
    int lw;
    lw = 0; lat0 = -1; lat1 = -1; busy_gap = 0;
    @(negedge clk);
    sq_base = s0_q.size();
    lq_base = l0_q.size();
    dn_base = done0_cnt;
    start = 1'b1;
    for (int cyc = 1; cyc <= LAT + 20; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done1 && lat1 < 0) lat1 = cyc;
      if (!busy0) busy_gap++;
      if (l_we0) lw++;
      if (abort_l >= 0 && l_we0 && lw == abort_l + 1) begin
        #1 rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {busy0, done0, s_we0, l_we0, s_addr0, l_addr0, busy1, l_we1},
              '0);
        check("rst_mid_data", {s_wdata0, l_wdata0}, '0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        return;
      end
      if (done0) begin
        lat0 = cyc;
        break;
      end
    end
    start = 1'b0;
    #1;
  endtask

  task automatic full_checks(input string tag, input logic [31:0] first_s,
                             input logic [31:0] first_l, input bit chk_first);
    int bad;
    logic [31:0] got;
    check({tag, "_lat0"}, lat0, LAT);
    check({tag, "_lat1"}, lat1, LAT);
    check({tag, "_s_writes"}, s0_q.size() - sq_base, NMIX + INIT_T);
    check({tag, "_l_writes"}, l0_q.size() - lq_base, NMIX);
    check({tag, "_done_pulses"}, done0_cnt - dn_base, 1);
    check({tag, "_busy_gap"}, busy_gap, 0);
`ifdef RC5_S_INIT_EN
    got = (s0_q.size() > sq_base + 2) ? s0_q[sq_base] : 'x;
    check({tag, "_init_s0"}, got, 32'hB7E15163);
    got = (s0_q.size() > sq_base + 2) ? s0_q[sq_base + 1] : 'x;
    check({tag, "_init_s1"}, got, 32'h5618CB1C);
    got = (s0_q.size() > sq_base + 2) ? s0_q[sq_base + 2] : 'x;
    check({tag, "_init_s2"}, got, 32'hF45044D5);
`endif
    if (chk_first) begin
      got = (s0_q.size() > sq_base + INIT_T) ? s0_q[sq_base + INIT_T] : 'x;
      check({tag, "_first_mix_s"}, got, first_s);
      got = (l0_q.size() > lq_base) ? l0_q[lq_base] : 'x;
      check({tag, "_first_mix_l"}, got, first_l);
    end
    model(4);
    bad = 0;
    for (int k = 0; k < 26; k++) if (s0_ram[k] !== m_s[k]) bad++;
    check({tag, "_final_S_bad_words"}, bad, 0);
    bad = 0;
    for (int k = 0; k < 4; k++) if (l0_ram[k] !== m_l[k]) bad++;
    check({tag, "_final_L_bad_words"}, bad, 0);
    model(1);
    bad = 0;
    for (int k = 0; k < 26; k++) if (s1_ram[k] !== m_s[k]) bad++;
    check({tag, "_c1_final_S_bad_words"}, bad, 0);
    check({tag, "_c1_final_L0"}, l1_ram[0], m_l[0]);
  endtask

  task automatic set_images(input logic [3:0][31:0] key);
    for (int k = 0; k < 4; k++) l_img[k] = key[k];
    for (int k = 0; k < 32; k++) begin
`ifdef RC5_S_INIT_EN
      s_img[k] = $urandom;
`else
      s_img[k] = (k < T) ? 32'hB7E15163 + 32'(k) * 32'h9E3779B9 : '0;
`endif
    end
  endtask

  typedef struct packed {
    logic [3:0][31:0] key;
    logic [31:0]      first_s;
    logic [31:0]      first_l;
    logic             chk_first;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [3:0][31:0] rk;
    rst = 1'b1; start = 1'b0; load_req = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {busy0, done0, s_we0, l_we0, s_addr0, l_addr0, busy1, done1}, '0);
    check("reset_data", {s_wdata0, l_wdata0}, '0);
    rst = 1'b0;

    // First mix writes: S[0] is key-independent; L[0] depends only on the key's first word.
    tbl[0] = '{key: '0, first_s: 32'hBF0A8B1D, first_l: 32'hB7E15163, chk_first: 1'b1};
    tbl[1] = '{key: {32'h0F0E0D0C, 32'h0B0A0908, 32'h12345678, 32'h00000001},
               first_s: 32'hBF0A8B1D, first_l: 32'hD7E15163, chk_first: 1'b1};
    tbl[2] = '{key: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
               first_s: 32'hBF0A8B1D, first_l: 32'h97E15163, chk_first: 1'b1};
    tbl[3] = '{key: {32'h0, 32'hDEADBEEF, 32'h0, 32'h80000000},
               first_s: 32'hBF0A8B1D, first_l: 32'hA7E15163, chk_first: 1'b1};
    for (int e = 4; e < 7; e++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      tbl[e] = '{key: rk, first_s: 32'hBF0A8B1D, first_l: '0, chk_first: 1'b0};
    end

    for (int e = 0; e < 7; e++) begin
      set_images(tbl[e].key);
      load_rams();
      run_op(1'b0, -1);
      full_checks($sformatf("vec%0d", e), tbl[e].first_s, tbl[e].first_l, tbl[e].chk_first);
      repeat (2) @(negedge clk);
    end

    // Reset during MIX_L of iteration 40, then a clean restart with a reloaded key.
    rk = {$urandom, $urandom, $urandom, $urandom};
    set_images(rk);
    load_rams();
    run_op(1'b0, 40);
    set_images(rk);
    load_rams();
    run_op(1'b0, -1);
    full_checks("after_rst", 32'hBF0A8B1D, '0, 1'b0);

    // start held high across the whole operation.
    rk = {$urandom, $urandom, $urandom, $urandom};
    set_images(rk);
    load_rams();
    run_op(1'b1, -1);
    full_checks("start_held", 32'hBF0A8B1D, '0, 1'b1 && 1'b0);
    repeat (3) @(negedge clk);
    check("start_held_idle_after", {busy0, busy1}, 2'b00);

    check("we_overlap_or_idle_write", proto_err, 0);
    check("c1_j_nonzero", j1_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rc5_key_mix.md
RC5_KEY_MIX -- requirements
Module: rc5_key_mix

Interface
REQ-001 Parameter W, default 32, word width in bits; supported values 16, 32, 64.
REQ-002 Parameter C, default 4, number of L words; C = ceil(key bytes / (W/8)).
REQ-003 Parameter R, default 12, round count; T = 2*(R+1) S words, derived, not overridable.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  begin key mixing; driven by the upstream L-load stage's done.
REQ-007 busy  out  1  high from the cycle after start is accepted until done.
REQ-008 done  out  1  one-cycle pulse when the final L write is issued.
REQ-009 S_address  out  $clog2(T)  S RAM address.
REQ-010 S_wdata  out  W  S RAM write data.
REQ-011 S_we  out  1  S RAM write enable, one cycle per write.
REQ-012 S_rdata  in  W  S RAM read data, combinational from S_address.
REQ-013 L_address  out  $clog2(C)  L RAM address.
REQ-014 L_wdata  out  W  L RAM write data.
REQ-015 L_we  out  1  L RAM write enable.
REQ-016 L_rdata  in  W  L RAM read data, combinational from L_address.

Function
REQ-017 States: IDLE, INIT_S, MIX_S, MIX_L, FINISH; encoding is free.
REQ-018 IDLE: start=1 moves to INIT_S, or to MIX_S when REQ-031 is compiled out; start is ignored in every other state.
REQ-019 INIT_S: one write per cycle for i=0..T-1; S[0]=P, S[i]=S[i-1]+Q mod 2^W; after i=T-1, go to MIX_S with i=j=0 and A=B=0.
REQ-020 Magic constants: W=16 P=B7E1, Q=9E37; W=32 P=B7E15163, Q=9E3779B9; W=64 P=B7E151628AED2A6B, Q=9E3779B97F4A7C15.
REQ-021 Mix iteration count N=3*max(T,C); each iteration is one MIX_S cycle followed by one MIX_L cycle.
REQ-022 MIX_S: S_address=i; A'=rotl(S_rdata+A+B, 3); S_wdata=A'; S_we=1; A is registered at the clock edge.
REQ-023 MIX_L: L_address=j; B'=rotl(L_rdata+A+B, (A+B) mod W), using the updated A; L_wdata=B'; L_we=1; B is registered at the clock edge.
REQ-024 All additions are modulo 2^W; the rotate amount uses the low log2(W) bits of A+B.
REQ-025 After MIX_L: i=(i+1) mod T and j=(j+1) mod C, with independent wrap-around.
REQ-026 The MIX_L cycle of iteration N-1 moves to FINISH; FINISH asserts done for one cycle, then returns to IDLE.
REQ-027 S_we and L_we are never high in the same cycle; both are 0 in IDLE and FINISH.
REQ-028 Latency from start to done: T+2N+1 cycles with init (183 at defaults), 2N+1 without.

Reset
REQ-029 rst forces IDLE immediately, including mid-operation; busy=0, done=0, S_we=0, L_we=0, all addresses and wdata=0, A=B=i=j=0.
REQ-030 After a mid-operation reset, RAM contents are undefined; a new start restarts the full sequence.

Configuration
REQ-031 Macro RC5_S_INIT_EN: when defined, INIT_S is compiled in and runs per REQ-019; when undefined, INIT_S and the P/Q logic are absent, S RAM is assumed preloaded, and start goes directly to MIX_S.

Verification
REQ-032 Defaults, RC5_S_INIT_EN on, start pulse -> S writes S[0]=B7E15163, S[1]=5618CB1C, S[2]=F45044D5 in consecutive cycles.
REQ-033 L RAM all-zero key (L[0..3]=0) -> first mix writes S[0]=BF0A8B1D, then L[0]=B7E15163.
REQ-034 Any key -> exactly 78 S writes and 78 L writes in mix; done at cycle 183 after start; final S RAM matches the software RC5 key schedule.
REQ-035 Assert rst during MIX_L of iteration 40 -> same-cycle return to IDLE with all outputs 0; a new start yields the correct full result.
REQ-036 start held high through the whole operation -> a single run, no restart while busy=1; C=1 -> j stays 0 throughout.
REQ-037 RC5_S_INIT_EN undefined, preloaded S -> the first write is the MIX_S write; done at cycle 157.
